// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains the async FIFO read port and sends 8N1 serial frames, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
`timescale 1ns/1ps
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             tx_enable,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    rd_en_d = 1'b0;
    cnt_d   = cnt_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_enable && !fifo_empty) begin
          state_d = S_FETCH;
          rd_en_d = 1'b1;
        end
      end
      S_FETCH: state_d = S_LOAD;
      // FIFO read data is valid during LOAD, one cycle after the pop.
      S_LOAD: begin
        shift_d = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
        tx_d    = 1'b0;
        baud_d  = '0;
        bit_d   = 3'd0;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          baud_d  = '0;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx with a queue-backed FIFO model.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int CNT_W = 3;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic             rd_clk = 1'b0;
  logic             rd_rst;
  logic             tx_enable;
  logic             fifo_empty = 1'b1;
  logic [7:0]       fifo_data  = 8'h00;
  logic             fifo_rd_en;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_en_cyc = -1;
  int pop_cnt  = 0;
  int underflow = 0;
  int exp_frames = 0;
  int last_fall_cyc = 0;
  int last_end_cyc  = 0;
  logic [7:0] fifo_q[$];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .tx_enable (tx_enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) cyc <= cyc + 1;

  // Registered-read FIFO: data appears the cycle after a pop.
  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      pop_cnt++;
      if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      else underflow++;
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(negedge rd_clk) if (fifo_rd_en) rd_en_cyc = cyc;

  function automatic logic line_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic check_frame(input logic [7:0] b, input int drop_at);
    bit   got = 0;
    logic exp;
    for (int t = 0; t < 200; t++) begin
      if (tx === 1'b0) begin
        got = 1;
        break;
      end
      @(negedge rd_clk);
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL frame_start byte=%h: tx stayed %b for 200 cycles, required a start bit", b, tx);
      return;
    end
    last_fall_cyc = cyc;
    n_checks++;
    if (rd_en_cyc != cyc - 2) begin
      n_fail++;
      $display("FAIL pop_to_start byte=%h: latency %0d, required 2", b, cyc - rd_en_cyc);
    end
    for (int i = 0; i < NB * CPB; i++) begin
      if (i > 0) @(negedge rd_clk);
      if (i == drop_at) tx_enable = 1'b0;
      exp = line_bit(b, i / CPB);
      n_checks++;
      if (tx !== exp || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL frame_bits byte=%h sample=%0d: tx=%b busy=%b, required tx=%b busy=1", b, i, tx, busy, exp);
      end
    end
    @(negedge rd_clk);
    exp_frames++;
    last_end_cyc = cyc;
    n_checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || frame_cnt !== CNT_W'(exp_frames)) begin
      n_fail++;
      $display("FAIL frame_end byte=%h: busy=%b tx=%b frame_cnt=%0d, required busy=0 tx=1 frame_cnt=%0d",
               b, busy, tx, frame_cnt, CNT_W'(exp_frames));
    end
  endtask

  task automatic test_reset();
    rd_rst = 1'b1;
    tx_enable = 1'b1;
    repeat (2) @(negedge rd_clk);
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || frame_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_values: tx=%b busy=%b rd_en=%b cnt=%0d, required 1/0/0/0", tx, busy, fifo_rd_en, frame_cnt);
    end
    rd_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge rd_clk);
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || frame_cnt !== '0) begin
        n_fail++;
        $display("FAIL idle_empty cycle=%0d: tx=%b busy=%b rd_en=%b cnt=%0d, required 1/0/0/0",
                 i, tx, busy, fifo_rd_en, frame_cnt);
      end
    end
  endtask

  task automatic test_single();
    int p0 = pop_cnt;
    fifo_q.push_back(8'hA5);
    check_frame(8'hA5, -1);
    n_checks++;
    if (pop_cnt - p0 != 1) begin
      n_fail++;
      $display("FAIL single_pops: %0d pop cycles, required 1", pop_cnt - p0);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = pop_cnt;
    int e;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    check_frame(8'h00, -1);
    e = last_end_cyc;
    check_frame(8'hFF, -1);
    n_checks++;
    if (last_fall_cyc - e != 3) begin
      n_fail++;
      $display("FAIL b2b_gap: %0d idle cycles, required 3", last_fall_cyc - e);
    end
    n_checks++;
    if (pop_cnt - p0 != 2) begin
      n_fail++;
      $display("FAIL b2b_pops: %0d, required 2", pop_cnt - p0);
    end
  endtask

  task automatic test_enable_gating();
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'h5A);
    check_frame(8'h3C, CPB * 3 + 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge rd_clk);
      n_checks++;
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL gated_idle cycle=%0d: rd_en=%b busy=%b, required 0/0", i, fifo_rd_en, busy);
      end
    end
    tx_enable = 1'b1;
    @(negedge rd_clk);
    n_checks++;
    if (fifo_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_pop: rd_en=%b one cycle after enable, required 1", fifo_rd_en);
    end
    check_frame(8'h5A, -1);
  endtask

  task automatic test_random();
    logic [7:0] bytes[$];
    logic [7:0] b;
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom_range(0, 255));
      bytes.push_back(b);
      fifo_q.push_back(b);
    end
    while (bytes.size() > 0) begin
      b = bytes.pop_front();
      check_frame(b, -1);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit got = 0;
    fifo_q.push_back(8'h96);
    for (int t = 0; t < 200; t++) begin
      @(negedge rd_clk);
      if (tx === 1'b0) begin
        got = 1;
        break;
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL midreset_start: tx=%b, required a start bit", tx);
    end
    repeat (CPB * 4 + 1) @(negedge rd_clk);
    rd_rst = 1'b1;
    #1;
    exp_frames = 0;
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || frame_cnt !== '0) begin
      n_fail++;
      $display("FAIL midreset_values: tx=%b busy=%b cnt=%0d, required 1/0/0", tx, busy, frame_cnt);
    end
    @(negedge rd_clk);
    rd_rst = 1'b0;
    fifo_q.push_back(8'hC3);
    check_frame(8'hC3, -1);
  endtask

  task automatic test_parity();
    fifo_q.push_back(8'h07);
    fifo_q.push_back(8'h03);
    check_frame(8'h07, -1);
    check_frame(8'h03, -1);
    n_checks++;
    if (underflow != 0) begin
      n_fail++;
      $display("FAIL pop_when_empty: %0d pops from empty FIFO, required 0", underflow);
    end
  endtask

  initial begin
    rd_rst = 1'b1;
    tx_enable = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_gating();
    test_random();
    test_reset_mid_frame();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
